// File: rtl/gyro_spi_reader.sv
// SPI mode-3 master for an L3G4200D-class gyro: writes one power-up
// configuration register after reset, then burst-reads the six rate bytes
// once per sample period and presents them as signed 16-bit X/Y/Z rates
// with a one-cycle VALID strobe.
module gyro_spi_reader #(
  parameter int          CLK_DIV       = 50,
  parameter int          SAMPLE_PERIOD = 1000000,
  parameter logic [7:0]  INIT_ADDR     = 8'h20,
  parameter logic [7:0]  INIT_DATA     = 8'h0F,
  parameter logic [5:0]  DATA_ADDR     = 6'h28
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        MISO,
  output logic        SCLK,
  output logic        MOSI,
  output logic        CS_N,
  output logic [15:0] DX,
  output logic [15:0] DY,
  output logic [15:0] DZ,
  output logic        VALID,
  output logic        BUSY
);

  // Divider counts one SCLK half-period and is reused for the CS_N-high gap.
  localparam int DW = $clog2(2 * CLK_DIV + 1);
  localparam int TW = $clog2(SAMPLE_PERIOD + 1);

  localparam logic [DW-1:0] HALF_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_LAST   = DW'(2 * CLK_DIV - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);

  // A transfer of N bits is 2N+2 half-periods: a lead-in half with SCLK
  // high, a low and a high half per bit, and a trailing high half.
  localparam logic [6:0] INIT_HALF_LAST = 7'd33;   // 16-bit write
  localparam logic [6:0] READ_HALF_LAST = 7'd113;  // 56-bit burst read

  // Outgoing bits are left-justified; MOSI always shows bit 55.
  localparam logic [55:0] INIT_WORD = {2'b00, INIT_ADDR[5:0], INIT_DATA, 40'h00_0000_0000};
  localparam logic [55:0] READ_WORD = {2'b11, DATA_ADDR, 48'h0000_0000_0000};

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_INIT_XFER = 3'd1,
    ST_GAP       = 3'd2,
    ST_WAIT      = 3'd3,
    ST_READ_XFER = 3'd4,
    ST_LATCH     = 3'd5
  } state_t;

  state_t         state_r,     state_s;
  logic [TW-1:0]  timer_r;
  logic [DW-1:0]  div_r,       div_s;
  logic [6:0]     half_r,      half_s;
  logic [6:0]     half_inc_s;
  logic [6:0]     last_half_s;
  logic [55:0]    tx_r,        tx_s;
  logic [47:0]    rx_r,        rx_s;
  logic           init_done_r, init_done_s;
  logic           sclk_r,      sclk_s;
  logic           cs_n_r,      cs_n_s;
  logic           mosi_r,      mosi_s;
  logic [15:0]    dx_r,        dx_s;
  logic [15:0]    dy_r,        dy_s;
  logic [15:0]    dz_r,        dz_s;
  logic           valid_r,     valid_s;
  logic           busy_r,      busy_s;
  logic           wrap_s;

  assign wrap_s      = (timer_r == TIMER_LAST);
  assign half_inc_s  = half_r + 7'd1;
  assign last_half_s = (state_r == ST_INIT_XFER) ? INIT_HALF_LAST : READ_HALF_LAST;

  // Free-running sample timer; it keeps counting through transfers so a
  // wrap that lands mid-transfer is simply missed rather than queued.
  always_ff @(posedge CLK) begin
    if (RST) begin
      timer_r <= {TW{1'b0}};
    end else if (wrap_s) begin
      timer_r <= {TW{1'b0}};
    end else begin
      timer_r <= timer_r + TW'(1);
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s     = state_r;
    div_s       = div_r;
    half_s      = half_r;
    tx_s        = tx_r;
    rx_s        = rx_r;
    init_done_s = init_done_r;
    sclk_s      = sclk_r;
    cs_n_s      = cs_n_r;
    mosi_s      = mosi_r;
    dx_s        = dx_r;
    dy_s        = dy_r;
    dz_s        = dz_r;
    valid_s     = 1'b0;

    case (state_r)
      ST_INIT: begin
        state_s = ST_INIT_XFER;
        cs_n_s  = 1'b0;
        sclk_s  = 1'b1;
        tx_s    = INIT_WORD;
        mosi_s  = INIT_WORD[55];
        div_s   = {DW{1'b0}};
        half_s  = 7'd0;
      end

      ST_INIT_XFER, ST_READ_XFER: begin
        if (div_r == HALF_LAST) begin
          div_s = {DW{1'b0}};
          if (half_r == last_half_s) begin
            // Trailing half done: release the bus.
            cs_n_s = 1'b1;
            sclk_s = 1'b1;
            half_s = 7'd0;
            if (state_r == ST_INIT_XFER) begin
              state_s = ST_GAP;
            end else begin
              state_s = ST_LATCH;
            end
          end else begin
            half_s = half_inc_s;
            if (half_inc_s == last_half_s) begin
              // Entering the trailing half: SCLK stays high, nothing moves.
              sclk_s = 1'b1;
            end else if (half_inc_s[0]) begin
              // Falling edge: present the current bit (bit 0 was already
              // driven when CS_N fell, so it does not toggle here).
              sclk_s = 1'b0;
              mosi_s = tx_r[55];
            end else begin
              // Rising edge: sample MISO and advance to the next bit.
              sclk_s = 1'b1;
              tx_s   = {tx_r[54:0], 1'b0};
              if (state_r == ST_READ_XFER) begin
                rx_s = {rx_r[46:0], MISO};
              end else begin
                rx_s = rx_r;
              end
            end
          end
        end else begin
          div_s = div_r + DW'(1);
        end
      end

      ST_GAP: begin
        if (div_r == GAP_LAST) begin
          state_s     = ST_WAIT;
          div_s       = {DW{1'b0}};
          init_done_s = 1'b1;
        end else begin
          div_s = div_r + DW'(1);
        end
      end

      ST_WAIT: begin
        if (wrap_s && EN) begin
          state_s = ST_READ_XFER;
          cs_n_s  = 1'b0;
          sclk_s  = 1'b1;
          tx_s    = READ_WORD;
          mosi_s  = READ_WORD[55];
          rx_s    = 48'h0000_0000_0000;
          div_s   = {DW{1'b0}};
          half_s  = 7'd0;
        end else begin
          state_s = ST_WAIT;
        end
      end

      ST_LATCH: begin
        // Bytes arrived as X_L,X_H,Y_L,Y_H,Z_L,Z_H from MSB downwards.
        dx_s    = {rx_r[39:32], rx_r[47:40]};
        dy_s    = {rx_r[23:16], rx_r[31:24]};
        dz_s    = {rx_r[7:0],   rx_r[15:8]};
        valid_s = 1'b1;
        state_s = ST_GAP;
        div_s   = {DW{1'b0}};
      end

      default: begin
        state_s = ST_INIT;
        cs_n_s  = 1'b1;
        sclk_s  = 1'b1;
      end
    endcase

    busy_s = ~init_done_s | ~cs_n_s;
  end

  // State and registered outputs; RST aborts any transfer at once.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= ST_INIT;
      div_r       <= {DW{1'b0}};
      half_r      <= 7'd0;
      tx_r        <= 56'h00_0000_0000_0000;
      rx_r        <= 48'h0000_0000_0000;
      init_done_r <= 1'b0;
      sclk_r      <= 1'b1;
      cs_n_r      <= 1'b1;
      mosi_r      <= 1'b0;
      dx_r        <= 16'h0000;
      dy_r        <= 16'h0000;
      dz_r        <= 16'h0000;
      valid_r     <= 1'b0;
      busy_r      <= 1'b1;
    end else begin
      state_r     <= state_s;
      div_r       <= div_s;
      half_r      <= half_s;
      tx_r        <= tx_s;
      rx_r        <= rx_s;
      init_done_r <= init_done_s;
      sclk_r      <= sclk_s;
      cs_n_r      <= cs_n_s;
      mosi_r      <= mosi_s;
      dx_r        <= dx_s;
      dy_r        <= dy_s;
      dz_r        <= dz_s;
      valid_r     <= valid_s;
      busy_r      <= busy_s;
    end
  end

  assign SCLK  = sclk_r;
  assign MOSI  = mosi_r;
  assign CS_N  = cs_n_r;
  assign DX    = dx_r;
  assign DY    = dy_r;
  assign DZ    = dz_r;
  assign VALID = valid_r;
  assign BUSY  = busy_r;

endmodule

// File: tb/tb_gyro_spi_reader.sv
// Directed bench for gyro_spi_reader with a behavioural SPI slave
// (CLK_DIV=2, SAMPLE_PERIOD=400).
module tb_gyro_spi_reader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic        MISO = 1'b0;
  logic        SCLK;
  logic        MOSI;
  logic        CS_N;
  logic [15:0] DX;
  logic [15:0] DY;
  logic [15:0] DZ;
  logic        VALID;
  logic        BUSY;

  gyro_spi_reader #(
    .CLK_DIV       (2),
    .SAMPLE_PERIOD (400)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .EN    (EN),
    .MISO  (MISO),
    .SCLK  (SCLK),
    .MOSI  (MOSI),
    .CS_N  (CS_N),
    .DX    (DX),
    .DY    (DY),
    .DZ    (DZ),
    .VALID (VALID),
    .BUSY  (BUSY)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Cycle counter for latency/period measurements.
  always @(posedge CLK) cyc <= cyc + 1;

  // Slave model: six data bytes after the command byte, MSB first,
  // driven on SCLK falling edges; MOSI captured on SCLK rising edges.
  logic [47:0] slave_data = 48'h0000_0000_0000;
  logic [63:0] mosi_sr    = 64'h0;
  int          fall_cnt   = 0;
  int          rise_cnt   = 0;
  logic        s_prev_cs  = 1'b1;
  logic        s_prev_sck = 1'b1;

  always @(SCLK or CS_N) begin
    logic [55:0] stream;
    stream = {8'h00, slave_data};
    if (CS_N === 1'b0 && s_prev_cs !== 1'b0) begin
      fall_cnt = 0;
      rise_cnt = 0;
      mosi_sr  = 64'h0;
    end
    if (SCLK === 1'b0 && s_prev_sck === 1'b1 && CS_N === 1'b0) begin
      if (fall_cnt < 56) MISO = stream[55 - fall_cnt];
      fall_cnt = fall_cnt + 1;
    end
    if (SCLK === 1'b1 && s_prev_sck === 1'b0 && CS_N === 1'b0) begin
      mosi_sr  = {mosi_sr[62:0], MOSI};
      rise_cnt = rise_cnt + 1;
    end
    s_prev_cs  = CS_N;
    s_prev_sck = SCLK;
  end

  // Bus-protocol monitor: MOSI may only move with an SCLK fall or a CS_N
  // fall, SCLK idles high, and the shortest CS_N-high gap is recorded.
  logic rst_q    = 1'b1;
  logic p_mosi   = 1'b0;
  logic p_sclk   = 1'b1;
  logic p_cs     = 1'b1;
  logic seen_low = 1'b0;
  int   mode_err = 0;
  int   hi_run   = 0;
  int   min_gap  = 1000;

  always @(posedge CLK) rst_q <= RST;

  always @(negedge CLK) begin
    if (rst_q !== 1'b0) begin
      seen_low <= 1'b0;
      hi_run   <= 0;
    end else begin
      if (MOSI !== p_mosi &&
          !((p_sclk === 1'b1 && SCLK === 1'b0) || (p_cs === 1'b1 && CS_N === 1'b0)))
        mode_err <= mode_err + 1;
      else if (CS_N === 1'b1 && SCLK !== 1'b1)
        mode_err <= mode_err + 1;
      if (CS_N === 1'b1) begin
        hi_run <= hi_run + 1;
      end else begin
        if (p_cs === 1'b1) begin
          if (seen_low && hi_run < min_gap) min_gap <= hi_run;
          seen_low <= 1'b1;
        end
        hi_run <= 0;
      end
    end
    p_mosi <= MOSI;
    p_sclk <= SCLK;
    p_cs   <= CS_N;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bounded wait on CS_N (0), VALID (1) or BUSY (2) reaching val.
  task automatic wait_for(input string tag, input int sel, input logic val,
                          input int budget, output int at);
    logic found;
    logic s;
    found = 1'b0;
    at    = -1;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge CLK);
      case (sel)
        0:       s = CS_N;
        1:       s = VALID;
        default: s = BUSY;
      endcase
      if (s === val) begin
        found = 1'b1;
        at    = cyc;
      end
    end
    check({tag, "_seen"}, 64'(found), 64'd1);
  endtask

  initial begin
    int          t_init;
    int          t_end;
    int          t;
    int          t_rd;
    int          t_v;
    int          t_prev;
    int          cs_lo;
    int          v_hi;
    logic        found_b;
    logic [55:0] mbits;
    logic [47:0] per_data [2];
    logic [15:0] per_dx   [2];
    logic [15:0] per_dy   [2];
    logic [15:0] per_dz   [2];

    per_data[0] = 48'h0100_FFFF_7F80; per_dx[0] = 16'h0001; per_dy[0] = 16'hFFFF; per_dz[0] = 16'h807F;
    per_data[1] = 48'h55AA_0000_FF7F; per_dx[1] = 16'hAA55; per_dy[1] = 16'h0000; per_dz[1] = 16'h7FFF;

    // Reset state
    RST = 1'b1;
    EN  = 1'b1;
    slave_data = 48'h3412_CDAB_0080;
    repeat (3) @(negedge CLK);
    check("rst_sclk",  64'(SCLK),  64'd1);
    check("rst_cs_n",  64'(CS_N),  64'd1);
    check("rst_mosi",  64'(MOSI),  64'd0);
    check("rst_dx",    64'(DX),    64'd0);
    check("rst_dy",    64'(DY),    64'd0);
    check("rst_dz",    64'(DZ),    64'd0);
    check("rst_valid", 64'(VALID), 64'd0);
    check("rst_busy",  64'(BUSY),  64'd1);

    // Init write: 0x20 then 0x0F, 16 SCLK cycles
    RST = 1'b0;
    wait_for("init_csn_fall", 0, 1'b0, 10, t_init);
    check("init_busy_low_cs", 64'(BUSY), 64'd1);
    wait_for("init_csn_rise", 0, 1'b1, 100, t_end);
    check("init_cs_len",  64'(t_end - t_init), 64'd68);
    check("init_falls",   64'(fall_cnt), 64'd16);
    check("init_rises",   64'(rise_cnt), 64'd16);
    check("init_mosi",    64'(mosi_sr[15:0]), 64'h200F);
    check("init_busy_gap", 64'(BUSY), 64'd1);
    check("init_dx",      64'(DX), 64'd0);
    check("init_valid",   64'(VALID), 64'd0);
    wait_for("init_busy_fall", 2, 1'b0, 20, t);
    check("init_busy_time", 64'(t - t_init), 64'd72);

    // First read at the first timer wrap
    wait_for("rd1_csn_fall", 0, 1'b0, 450, t_rd);
    check("rd1_start", 64'(t_rd - t_init), 64'd399);
    check("rd1_busy", 64'(BUSY), 64'd1);
    wait_for("rd1_valid", 1, 1'b1, 300, t_v);
    check("rd1_latency", 64'(t_v - t_rd), 64'd229);
    check("rd1_dx", 64'(DX), 64'h1234);
    check("rd1_dy", 64'(DY), 64'hABCD);
    check("rd1_dz", 64'(DZ), 64'h8000);
    check("rd1_falls", 64'(fall_cnt), 64'd56);
    check("rd1_rises", 64'(rise_cnt), 64'd56);
    mbits = mosi_sr[55:0];
    check("rd1_mosi", 64'(mbits), 64'h00E8_0000_0000_0000);
    check("rd1_busy_idle", 64'(BUSY), 64'd0);
    @(negedge CLK);
    check("rd1_valid_pulse", 64'(VALID), 64'd0);

    // Periodic reads with new data each period
    t_prev = t_v;
    for (int k = 0; k < 2; k++) begin
      slave_data = per_data[k];
      repeat (199) @(negedge CLK);
      check("per_hold_valid", 64'(VALID), 64'd0);
      check("per_hold_dx", 64'(DX), (k == 0) ? 64'h1234 : 64'(per_dx[0]));
      wait_for("per_valid", 1, 1'b1, 300, t);
      check("per_period", 64'(t - t_prev), 64'd400);
      check("per_dx", 64'(DX), 64'(per_dx[k]));
      check("per_dy", 64'(DY), 64'(per_dy[k]));
      check("per_dz", 64'(DZ), 64'(per_dz[k]));
      t_prev = t;
    end

    // EN low across a wrap: no transfer, outputs hold
    EN = 1'b0;
    slave_data = 48'h8000_0180_FEFF;
    cs_lo = 0;
    v_hi  = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (CS_N !== 1'b1) cs_lo++;
      if (VALID !== 1'b0) v_hi++;
    end
    check("en_no_cs",    64'(cs_lo), 64'd0);
    check("en_no_valid", 64'(v_hi),  64'd0);
    check("en_dx_hold",  64'(DX),    64'hAA55);
    check("en_busy",     64'(BUSY),  64'd0);
    EN = 1'b1;
    wait_for("en_csn_fall", 0, 1'b0, 400, t_rd);
    check("en_resume_start", 64'(t_rd - t_prev), 64'd571);
    wait_for("en_valid", 1, 1'b1, 300, t_v);
    check("en_latency", 64'(t_v - t_rd), 64'd229);
    check("en_dx", 64'(DX), 64'h0080);
    check("en_dy", 64'(DY), 64'h8001);
    check("en_dz", 64'(DZ), 64'hFFFE);

    // Reset after bit 30 of a read
    wait_for("mid_csn_fall", 0, 1'b0, 450, t);
    check("mid_start", 64'(t - t_v), 64'd171);
    found_b = 1'b0;
    for (int i = 0; i < 300 && !found_b; i++) begin
      @(negedge CLK);
      if (rise_cnt >= 31) found_b = 1'b1;
    end
    check("mid_bit30_seen", 64'(found_b), 64'd1);
    check("mid_bit30_cnt", 64'(rise_cnt), 64'd31);
    RST = 1'b1;
    @(negedge CLK);
    check("mid_cs_n",  64'(CS_N),  64'd1);
    check("mid_sclk",  64'(SCLK),  64'd1);
    check("mid_dx",    64'(DX),    64'd0);
    check("mid_dy",    64'(DY),    64'd0);
    check("mid_dz",    64'(DZ),    64'd0);
    check("mid_valid", 64'(VALID), 64'd0);
    check("mid_busy",  64'(BUSY),  64'd1);
    RST = 1'b0;
    wait_for("reinit_csn_fall", 0, 1'b0, 10, t_init);
    wait_for("reinit_csn_rise", 0, 1'b1, 100, t_end);
    check("reinit_len",   64'(t_end - t_init), 64'd68);
    check("reinit_falls", 64'(fall_cnt), 64'd16);
    check("reinit_mosi",  64'(mosi_sr[15:0]), 64'h200F);
    check("reinit_dx",    64'(DX), 64'd0);
    check("reinit_valid", 64'(VALID), 64'd0);

    // Protocol-level observations accumulated over the whole run
    check("mode_violations", 64'(mode_err), 64'd0);
    check("cs_gap_min_ge4",  64'(min_gap >= 4), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
